// File: rtl/edge_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// edge_pkg
// Shared constants and parameter-legality helpers for the edge detector
// family (edge_sync, edge_detector, edge_detector_s).
// ----------------------------------------------------------------------------
package edge_pkg;

    // Synchronizer depth used by the asynchronous-input wrapper.
    localparam int EDGE_SYNC_DEFAULT = 2;

    // Legal synchronizer depths: 0 (no synchronizer) or 2..4 flops.
    // A single flop does not meaningfully reduce metastability risk.
    localparam int EDGE_SYNC_MIN = 2;
    localparam int EDGE_SYNC_MAX = 4;

    function automatic bit sync_stages_legal(input int n);
        return (n == 0) || ((n >= EDGE_SYNC_MIN) && (n <= EDGE_SYNC_MAX));
    endfunction

    function automatic bit reg_out_legal(input int n);
        return (n == 0) || (n == 1);
    endfunction

endpackage

// File: rtl/edge_detector_s.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// edge_detector_s
// Edge detector for asynchronous inputs: two-flop synchronizer in front of
// detection and registered outputs. A level sampled at clock edge E0 yields
// a pulse high from edge E2 to edge E3.
//
// Ports:
//   sig    in   WIDTH  asynchronous level(s)
//   clk    in   1      clock
//   rst_n  in   1      synchronous active-low reset
//   rise   out  WIDTH  registered one-cycle rise pulse
//   fall   out  WIDTH  registered one-cycle fall pulse
// ----------------------------------------------------------------------------
module edge_detector_s
    import edge_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] sig,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    edge_detector #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (EDGE_SYNC_DEFAULT),
        .REG_OUT     (1)
    ) u_core (
        .sig   (sig),
        .clk   (clk),
        .rst_n (rst_n),
        .rise  (rise),
        .fall  (fall)
    );

endmodule

// File: rtl/edge_sync.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// edge_sync
// N-stage flop chain that brings a (possibly asynchronous) level into the
// clk domain. Every stage clears to 0 on a synchronous active-low reset.
//
// Ports:
//   clk    in   1      clock, all flops update on its rising edge
//   rst_n  in   1      synchronous active-low reset
//   sig    in   WIDTH  raw input level(s)
//   sync   out  WIDTH  output of the last chain stage
// ----------------------------------------------------------------------------
module edge_sync
    import edge_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = EDGE_SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sync
);

    logic [WIDTH-1:0] chain_reg [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        chain_reg[gi] <= '0;
                    end else begin
                        chain_reg[gi] <= sig;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        chain_reg[gi] <= '0;
                    end else begin
                        chain_reg[gi] <= chain_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign sync = chain_reg[STAGES-1];

endmodule

// File: rtl/edge_detector.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// edge_detector
// Per-bit rising/falling edge detector. Each bit of sig is (optionally)
// synchronized, compared against its value from the previous clock, and a
// one-cycle rise/fall pulse is produced per level change.
//
// Parameters:
//   WIDTH        number of independent input bits
//   SYNC_STAGES  0 (sig used directly) or 2..4 synchronizer flops
//   REG_OUT      0: combinational outputs, 1: registered outputs
//
// Ports:
//   sig    in   WIDTH  monitored level(s)
//   clk    in   1      clock
//   rst_n  in   1      synchronous active-low reset
//   rise   out  WIDTH  one-cycle pulse per 0->1 change of the matching bit
//   fall   out  WIDTH  one-cycle pulse per 1->0 change of the matching bit
// ----------------------------------------------------------------------------
module edge_detector
    import edge_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int REG_OUT     = 0
) (
    input  logic [WIDTH-1:0] sig,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Elaboration-time parameter checks.
    generate
        if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
            $error("edge_detector: SYNC_STAGES=%0d is illegal (use 0 or 2..4)", SYNC_STAGES);
        end
        if (!reg_out_legal(REG_OUT)) begin : g_bad_reg
            $error("edge_detector: REG_OUT=%0d is illegal (use 0 or 1)", REG_OUT);
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("edge_detector: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] h_reg;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;

    // Sample value: raw input or the tail of the synchronizer chain.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = sig;
        end else begin : g_sync
            edge_sync #(
                .WIDTH  (WIDTH),
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .sig   (sig),
                .sync  (s)
            );
        end
    endgenerate

    // History starts from 0 after reset, so a level already high at release
    // is reported as exactly one rise and never as a fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_reg <= '0;
        end else begin
            h_reg <= s;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_detect
            assign rise_c[gi] =  s[gi] & ~h_reg[gi];
            assign fall_c[gi] = ~s[gi] &  h_reg[gi];
        end
    endgenerate

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] rise_reg;
            logic [WIDTH-1:0] fall_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rise_reg <= '0;
                    fall_reg <= '0;
                end else begin
                    rise_reg <= rise_c;
                    fall_reg <= fall_c;
                end
            end

            assign rise = rise_reg;
            assign fall = fall_reg;
        end else begin : g_comb_out
            // Mask with rst_n so a pulse is cut immediately when reset asserts,
            // not only at the next clock edge.
            assign rise = rise_c & {WIDTH{rst_n}};
            assign fall = fall_c & {WIDTH{rst_n}};
        end
    endgenerate

endmodule

// File: tb/tb_edge_detector.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_edge_detector
// Directed bench for edge_detector (defaults and WIDTH=4) and edge_detector_s.
// ----------------------------------------------------------------------------
module tb_edge_detector;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sig_a = 1'b0;
    logic       rise_a, fall_a;
    logic       sig_s = 1'b0;
    logic       rise_s, fall_s;
    logic [3:0] sig_w = 4'h0;
    logic [3:0] rise_w, fall_w;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Wide-port vectors: applied level, expected rise, expected fall.
    logic [3:0] wv [6] = '{4'b0010, 4'b0001, 4'b1101, 4'b1101, 4'b0110, 4'b0000};
    logic [3:0] wr [6] = '{4'b0010, 4'b0001, 4'b1100, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] wf [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1001, 4'b0110};

    always #2 clk = ~clk;

    edge_detector dut_a (
        .sig   (sig_a),
        .clk   (clk),
        .rst_n (rst_n),
        .rise  (rise_a),
        .fall  (fall_a)
    );

    edge_detector_s #(.WIDTH(1)) dut_s (
        .sig   (sig_s),
        .clk   (clk),
        .rst_n (rst_n),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    edge_detector #(.WIDTH(4)) dut_w (
        .sig   (sig_w),
        .clk   (clk),
        .rst_n (rst_n),
        .rise  (rise_w),
        .fall  (fall_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: value=%0h @%0t", tag, got, $time);
        end
    endtask

    // rise and fall of one bit must never be high together.
    always @(negedge clk) begin
        if (mon_en) begin
            check("excl_a", 32'(rise_a & fall_a), 0);
            check("excl_s", 32'(rise_s & fall_s), 0);
            check("excl_w", 32'(rise_w & fall_w), 0);
        end
    end

    // Off-edge change on the synchronized variant; pulse expected E2..E3.
    task automatic async_edge(input logic v, input int off, input string tag);
        logic [1:0] exp;
        exp = v ? 2'b10 : 2'b01;
        @(posedge clk);
        #(off) sig_s = v;
        @(posedge clk);                       // E0
        #1 check({tag, "_e0"}, 32'({rise_s, fall_s}), 0);
        @(posedge clk);                       // E1
        #1 check({tag, "_e1"}, 32'({rise_s, fall_s}), 0);
        @(posedge clk);                       // E2
        #1 check({tag, "_e2"}, 32'({rise_s, fall_s}), 32'(exp));
        @(posedge clk);                       // E3
        #1 check({tag, "_e3"}, 32'({rise_s, fall_s}), 0);
    endtask

    initial begin
        // ---------------- reset with toggling inputs ----------------
        rst_n = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_all", 32'({rise_a, fall_a, rise_s, fall_s, rise_w, fall_w}), 0);
            sig_a = ~sig_a;
            sig_s = ~sig_s;
            sig_w = ~sig_w;
            #1 check("rst_comb", 32'({rise_a, fall_a, rise_w, fall_w}), 0);
        end

        // ---------------- release with sig=0 ----------------
        @(negedge clk);
        sig_a = 1'b0;
        sig_s = 1'b0;
        sig_w = 4'h0;
        rst_n = 1'b1;
        #1 check("rel0_comb", 32'({rise_a, fall_a, rise_w, fall_w}), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rel0_idle", 32'({rise_a, fall_a, rise_s, fall_s, rise_w, fall_w}), 0);
        end

        // ---------------- synchronous rise then fall ----------------
        @(negedge clk);
        sig_a = 1'b1;
        #1 check("a_rise", 32'({rise_a, fall_a}), 2);
        @(negedge clk);
        check("a_rise_end", 32'({rise_a, fall_a}), 0);
        repeat (2) begin
            @(negedge clk);
            check("a_hold", 32'({rise_a, fall_a}), 0);
        end
        sig_a = 1'b0;
        #1 check("a_fall", 32'({rise_a, fall_a}), 1);
        @(negedge clk);
        check("a_fall_end", 32'({rise_a, fall_a}), 0);
        @(negedge clk);
        check("a_quiet", 32'({rise_a, fall_a}), 0);

        // ---------------- asynchronous input on wrapper ----------------
        async_edge(1'b1, 3, "s_rise3");
        async_edge(1'b0, 1, "s_fall1");
        async_edge(1'b1, 1, "s_rise1");
        async_edge(1'b0, 3, "s_fall3");

        // ---------------- reset asserted mid-pulse ----------------
        @(posedge clk);
        #1 sig_s = 1'b1;
        repeat (3) @(posedge clk);            // E0, E1, E2
        #1 check("s_pulse", 32'({rise_s, fall_s}), 2);
        @(negedge clk);
        sig_a = 1'b1;
        #0.5 check("a_pulse", 32'({rise_a, fall_a}), 2);
        rst_n = 1'b0;
        #0.5 check("a_cut", 32'({rise_a, fall_a}), 0);
        check("s_hold", 32'({rise_s, fall_s}), 2);
        @(posedge clk);
        #1 check("s_cut", 32'({rise_s, fall_s}), 0);

        // toggle 1->0->1 while reset is held
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sig_a = (i == 1);
            sig_s = (i == 1);
            #1 check("rst_mid", 32'({rise_a, fall_a, rise_s, fall_s}), 0);
        end
        @(negedge clk);
        check("rst_mid_end", 32'({rise_a, fall_a, rise_s, fall_s}), 0);

        // release with sig=1: one rise each, normal latency, no fall
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel1_a", 32'({rise_a, fall_a}), 2);
        check("rel1_s0", 32'({rise_s, fall_s}), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("rel1_a_after", 32'({rise_a, fall_a}), 0);
            check("rel1_s", 32'({rise_s, fall_s}), (k == 3) ? 2 : 0);
        end

        // ---------------- back-to-back toggles ----------------
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sig_a = ~sig_a;
            #1 check("a_b2b", 32'({rise_a, fall_a}), sig_a ? 2 : 1);
        end
        @(negedge clk);
        check("a_b2b_end", 32'({rise_a, fall_a}), 0);

        // ---------------- WIDTH=4 independent bits ----------------
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sig_w = wv[k];
            #1;
            check("w_rise", 32'(rise_w), 32'(wr[k]));
            check("w_fall", 32'(fall_w), 32'(wf[k]));
        end
        @(negedge clk);
        check("w_end", 32'({rise_w, fall_w}), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
